// File: rtl/mealy_pattern_fsm_pkg.sv
// Elaboration-time helpers for the serial pattern detector: KMP failure function,
// next-progress function and the flattened transition table builder.
package fsm_pkg;

    localparam int MAX_LEN = 16;
    localparam int MAX_PW  = 4;
    localparam int TBL_W   = MAX_LEN * 2 * MAX_PW;

    // Width of the progress register; a 2-bit pattern still needs one bit.
    function automatic int prog_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Bit t of the pattern in arrival order (t=0 is the first bit expected).
    function automatic logic pat_bit(input logic [15:0] pattern, input int len, input int t);
        return pattern[4'(len - 1 - t)];
    endfunction

    // Pattern re-ordered so that index t holds the t-th expected bit.
    function automatic logic [15:0] bit_order(input logic [15:0] pattern, input int len);
        logic [15:0] r;
        r = '0;
        for (int t = 0; t < len; t++) r[t] = pat_bit(pattern, len, t);
        return r;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of its first k bits.
    function automatic int failure(input logic [15:0] pattern, input int len, input int k);
        int  best;
        logic ok;
        best = 0;
        for (int m = 1; m < k; m++) begin
            ok = 1'b1;
            for (int t = 0; t < m; t++)
                if (pat_bit(pattern, len, t) != pat_bit(pattern, len, k - m + t)) ok = 1'b0;
            if (ok) best = m;
        end
        return best;
    endfunction

    // Progress after consuming bit b from progress prog (overlapping semantics).
    function automatic int next_prog(input logic [15:0] pattern, input int len,
                                     input int prog, input logic b);
        int   best;
        int   kmax;
        logic ok;
        logic sb;
        if (prog == len - 1 && b == pat_bit(pattern, len, prog))
            return failure(pattern, len, len);
        best = 0;
        kmax = (prog + 1 < len - 1) ? prog + 1 : len - 1;
        for (int k = 1; k <= kmax; k++) begin
            ok = 1'b1;
            for (int t = 0; t < k; t++) begin
                // Candidate string is the first prog pattern bits followed by b.
                sb = (prog + 1 - k + t < prog) ? pat_bit(pattern, len, prog + 1 - k + t) : b;
                if (pat_bit(pattern, len, t) != sb) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Entry (p*2+b) occupies MAX_PW bits and holds the next progress.
    function automatic logic [TBL_W-1:0] build_table(input logic [15:0] pattern, input int len,
                                                     input int overlap);
        logic [TBL_W-1:0] tbl;
        int               nxt;
        tbl = '0;
        for (int p = 0; p < len; p++) begin
            for (int b = 0; b < 2; b++) begin
                if (overlap == 0 && p == len - 1 && 1'(b) == pat_bit(pattern, len, p))
                    nxt = 0;
                else
                    nxt = next_prog(pattern, len, p, 1'(b));
                tbl[(p * 2 + b) * MAX_PW +: MAX_PW] = 4'(nxt);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and soft clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstN)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/mealy_pattern_fsm.sv
// Mealy serial pattern detector: KMP progress register, zero-latency match/fall-back
// outputs and a saturating match counter.
module mealy_pattern_fsm
    import fsm_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     i,
    input  logic                     j,
    input  logic                     clear,
    output logic                     x,
    output logic                     y,
    output logic [prog_w(LEN)-1:0]   state,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int               PW    = prog_w(LEN);
    localparam logic [15:0]      PBITS = bit_order(16'(PATTERN), LEN);
    localparam logic [TBL_W-1:0] TBL   = build_table(16'(PATTERN), LEN, OVERLAP);

    typedef logic [PW-1:0] prog_t;
    localparam prog_t LAST = prog_t'(LEN - 1);

    prog_t          p_q;
    prog_t          p_d;
    prog_t          p_next;
    logic [3:0]     p_ext;
    logic [3:0]     tbl_ent;
    logic           bit_ok;
    logic           live;

    // j is a valid strobe with no back-pressure: every cycle with j=1 consumes i.
    always_ff @(posedge clk) begin
        if (!rstN)
            p_q <= '0;
        else
            p_q <= p_d;
    end

    always_comb begin
        p_ext   = 4'(p_q);
        tbl_ent = TBL[{p_ext, i, 2'b00} +: 4];
        p_next  = tbl_ent[PW-1:0];
        bit_ok  = (i == PBITS[p_ext]);
        live    = rstN && !clear && j;

        x = live && (p_q == LAST) && bit_ok;
        y = live && (p_q != '0) && !x && (p_next <= p_q);

        p_d = p_q;
        if (clear)
            p_d = '0;
        else if (j)
            p_d = p_next;
    end

    assign state = p_q;

    // x is already suppressed by reset and clear, so it alone qualifies the count.
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rstN (rstN),
        .clr  (clear),
        .inc  (x),
        .q    (match_cnt)
    );

endmodule

// File: tb/tb_mealy_pattern_fsm.sv
// Bench for mealy_pattern_fsm: four configurations driven in lock-step, checked against
// a string-matching reference model (history of consumed bits vs. pattern).
module tb_mealy_pattern_fsm;

    logic clk;
    logic rstN;
    logic i;
    logic j;
    logic clear;

    logic       x0, y0, x1, y1, x2, y2, x3, y3;
    logic [1:0] st0, st1, st2;
    logic [2:0] st3;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [3:0] cnt3;

    int checks = 0;
    int errors = 0;

    // Configuration table of the reference model.
    int          len_a [4] = '{4, 4, 4, 5};
    logic [15:0] pat_a [4] = '{16'b1011, 16'b1011, 16'b1011, 16'b10010};
    int          ovl_a [4] = '{1, 0, 1, 1};
    int          max_a [4] = '{255, 255, 3, 15};

    bit hq  [4][$];
    int mcnt[4];

    logic   obs_x [4];
    logic   obs_y [4];
    integer obs_st[4];
    integer obs_c [4];

    assign obs_x[0] = x0;  assign obs_y[0] = y0;
    assign obs_x[1] = x1;  assign obs_y[1] = y1;
    assign obs_x[2] = x2;  assign obs_y[2] = y2;
    assign obs_x[3] = x3;  assign obs_y[3] = y3;
    assign obs_st[0] = integer'(st0);  assign obs_c[0] = integer'(cnt0);
    assign obs_st[1] = integer'(st1);  assign obs_c[1] = integer'(cnt1);
    assign obs_st[2] = integer'(st2);  assign obs_c[2] = integer'(cnt2);
    assign obs_st[3] = integer'(st3);  assign obs_c[3] = integer'(cnt3);

    mealy_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut0 (
        .clk(clk), .rstN(rstN), .i(i), .j(j), .clear(clear),
        .x(x0), .y(y0), .state(st0), .match_cnt(cnt0));
    mealy_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut1 (
        .clk(clk), .rstN(rstN), .i(i), .j(j), .clear(clear),
        .x(x1), .y(y1), .state(st1), .match_cnt(cnt1));
    mealy_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut2 (
        .clk(clk), .rstN(rstN), .i(i), .j(j), .clear(clear),
        .x(x2), .y(y2), .state(st2), .match_cnt(cnt2));
    mealy_pattern_fsm #(.LEN(5), .PATTERN(5'b10010), .OVERLAP(1), .CNT_W(4)) dut3 (
        .clk(clk), .rstN(rstN), .i(i), .j(j), .clear(clear),
        .x(x3), .y(y3), .state(st3), .match_cnt(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit pbit(input int n, input int t);
        logic [15:0] p;
        p = pat_a[n];
        return p[4'(len_a[n] - 1 - t)];
    endfunction

    // Longest k < LEN such that the last k history bits equal the first k pattern bits.
    function automatic int prog_of(input int n, input bit h[$]);
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < len_a[n]; k++) begin
            if (k <= h.size()) begin
                ok = 1'b1;
                for (int t = 0; t < k; t++)
                    if (h[h.size() - k + t] != pbit(n, t)) ok = 1'b0;
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic bit is_match(input int n, input bit h[$]);
        bit ok;
        if (h.size() < len_a[n]) return 1'b0;
        ok = 1'b1;
        for (int t = 0; t < len_a[n]; t++)
            if (h[h.size() - len_a[n] + t] != pbit(n, t)) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ii, input bit jj, input bit cl, input bit rn);
        bit hn[$];
        int p;
        int pn;
        bit m;
        bit ex;
        bit ey;
        @(negedge clk);
        i = ii; j = jj; clear = cl; rstN = rn;
        #1;
        for (int n = 0; n < 4; n++) begin
            hn = hq[n];
            hn.push_back(ii);
            p  = prog_of(n, hq[n]);
            m  = is_match(n, hn);
            pn = prog_of(n, hn);
            ex = rn && !cl && jj && m;
            ey = rn && !cl && jj && (p != 0) && !ex && (pn <= p);
            chk($sformatf("x%0d", n),     integer'(obs_x[n]), integer'(ex));
            chk($sformatf("y%0d", n),     integer'(obs_y[n]), integer'(ey));
            chk($sformatf("state%0d", n), obs_st[n], p);
            chk($sformatf("cnt%0d", n),   obs_c[n], mcnt[n]);
            if (!rn || cl) begin
                hq[n].delete();
                mcnt[n] = 0;
            end else if (jj) begin
                if (m && mcnt[n] < max_a[n]) mcnt[n]++;
                if (m && ovl_a[n] == 0) begin
                    hq[n].delete();
                end else begin
                    hq[n] = hn;
                    while (hq[n].size() > len_a[n] - 1) void'(hq[n].pop_front());
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic feed(input logic [15:0] bits, input int nb);
        for (int k = nb - 1; k >= 0; k--) step(bits[k], 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        i = 1'b0; j = 1'b0; clear = 1'b0; rstN = 1'b0;
        for (int n = 0; n < 4; n++) mcnt[n] = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Overlapping vs. restart behaviour on 1,0,1,1,0,1,1.
        feed(16'b1011011, 7);
        // Fall-back: 1,0,1,0 drops 3->2, then 1,1 from empty stays at 1.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed(16'b1010, 4);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed(16'b11, 2);
        // Valid gap with toggling data, then completion.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed(16'b10, 2);
        for (int k = 0; k < 3; k++) step(1'(k % 2), 1'b0, 1'b0, 1'b1);
        feed(16'b11, 2);
        // Five back-to-back matches: 2-bit counter saturates at 3.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) feed(16'b1011, 4);
        // Reset, clear, and both together while at progress 3.
        feed(16'b101, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        feed(16'b0101, 4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        feed(16'b0101, 4);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Randomised traffic with occasional clears and resets.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
